// File: rtl/hpdcache_refill_ack_pkg.sv
// Shared types and width helpers for the refill acknowledge path.
package hpdcache_pkg;

  localparam int unsigned SET_W = 7;
  localparam int unsigned TAG_W = 24;
  localparam int unsigned TID_W = 6;
  localparam int unsigned SID_W = 3;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned mset_w(input int unsigned sets);
    return clog2_min1(sets);
  endfunction

  function automatic int unsigned mway_w(input int unsigned ways);
    return clog2_min1(ways);
  endfunction

  typedef enum logic [2:0] {
    RF_IDLE,
    RF_RECV,
    RF_ACK_REQ,
    RF_ACK_RD,
    RF_REFILL,
    RF_RSP
  } refill_fsm_e;

  typedef struct packed {
    logic [TID_W-1:0] req_id;
    logic [SID_W-1:0] src_id;
    logic [SET_W-1:0] cache_set;
    logic [TAG_W-1:0] cache_tag;
    logic             need_rsp;
    logic             is_prefetch;
  } mshr_ack_entry_t;

endpackage

// File: rtl/hpdcache_refill_linebuf.sv
// Refill line buffer: one register per memory beat, written per beat, read as a flat line.
module hpdcache_refill_linebuf
  import hpdcache_pkg::*;
#(
  parameter int unsigned BEATS  = 2,
  parameter int unsigned BEAT_W = 128,
  localparam int unsigned AW    = clog2_min1(BEATS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [BEAT_W-1:0]       wdata_i,
  output logic [BEATS*BEAT_W-1:0] line_o
);

  logic [BEAT_W-1:0] mem_q [BEATS];
  logic [BEAT_W-1:0] mem_d [BEATS];

  always_comb begin
    for (int unsigned i = 0; i < BEATS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i && (32'(waddr_i) < BEATS)) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    line_o = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      line_o[i*BEAT_W +: BEAT_W] = mem_q[i];
    end
  end

endmodule

// File: rtl/hpdcache_refill_ack.sv
// Collects a multi-beat memory refill, acknowledges the owning MSHR slot, then issues
// the cache refill write and, when the entry asks for it, the core response.
module hpdcache_refill_ack
  import hpdcache_pkg::*;
#(
  parameter int unsigned MSHR_SETS = 32,
  parameter int unsigned MSHR_WAYS = 2,
  parameter int unsigned BEATS     = 2,
  parameter int unsigned BEAT_W    = 128,
  parameter int unsigned WORD_W    = 64,
  localparam int unsigned MSET_W   = mset_w(MSHR_SETS),
  localparam int unsigned MWAY_W   = mway_w(MSHR_WAYS),
  localparam int unsigned ID_W     = MWAY_W + MSET_W,
  localparam int unsigned LINE_W   = BEATS * BEAT_W,
  localparam int unsigned WIDX_W   = clog2_min1(LINE_W / WORD_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_rsp_valid_i,
  output logic              mem_rsp_ready_o,
  input  logic [ID_W-1:0]   mem_rsp_id_i,
  input  logic [BEAT_W-1:0] mem_rsp_data_i,
  input  logic              mem_rsp_error_i,
  input  logic              mem_rsp_last_i,
  input  logic              ack_gnt_i,
  output logic              ack_o,
  output logic              ack_cs_o,
  output logic [MSET_W-1:0] ack_set_o,
  output logic [MWAY_W-1:0] ack_way_o,
  input  logic [TID_W-1:0]  ack_req_id_i,
  input  logic [SID_W-1:0]  ack_src_id_i,
  input  logic [SET_W-1:0]  ack_cache_set_i,
  input  logic [TAG_W-1:0]  ack_cache_tag_i,
  input  logic [WIDX_W-1:0] ack_word_i,
  input  logic              ack_need_rsp_i,
  input  logic              ack_is_prefetch_i,
  output logic              refill_valid_o,
  input  logic              refill_ready_i,
  output logic [SET_W-1:0]  refill_set_o,
  output logic [TAG_W-1:0]  refill_tag_o,
  output logic [LINE_W-1:0] refill_data_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_data_o,
  output logic [TID_W-1:0]  rsp_tid_o,
  output logic [SID_W-1:0]  rsp_sid_o,
  output logic              rsp_error_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = clog2_min1(BEATS);

  refill_fsm_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [ID_W-1:0] id_q, id_d;
  mshr_ack_entry_t entry_q, entry_d;
  logic [WIDX_W-1:0] word_q, word_d;

  logic              beat_we;
  logic              beat_at_end;
  logic [LINE_W-1:0] line;

  hpdcache_refill_linebuf #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_linebuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (beat_we),
    .waddr_i (cnt_q),
    .wdata_i (mem_rsp_data_i),
    .line_o  (line)
  );

  assign beat_at_end = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    id_d    = id_q;
    entry_d = entry_q;
    word_d  = word_q;
    beat_we = 1'b0;

    unique case (state_q)
      RF_IDLE, RF_RECV: begin
        if (mem_rsp_valid_i) begin
          beat_we = 1'b1;
          if (state_q == RF_IDLE) id_d = mem_rsp_id_i;
          // An early last leaves a partially stale line, so the refill is marked bad.
          if (mem_rsp_last_i || beat_at_end) begin
            state_d = RF_ACK_REQ;
            cnt_d   = '0;
            err_d   = err_q | mem_rsp_error_i | ~beat_at_end;
          end else begin
            state_d = RF_RECV;
            cnt_d   = cnt_q + 1'b1;
            err_d   = err_q | mem_rsp_error_i;
          end
        end
      end
      RF_ACK_REQ: begin
        if (ack_gnt_i) state_d = RF_ACK_RD;
      end
      RF_ACK_RD: begin
        entry_d = '{req_id:      ack_req_id_i,
                    src_id:      ack_src_id_i,
                    cache_set:   ack_cache_set_i,
                    cache_tag:   ack_cache_tag_i,
                    need_rsp:    ack_need_rsp_i,
                    is_prefetch: ack_is_prefetch_i};
        word_d  = ack_word_i;
        if (!err_q) begin
          state_d = RF_REFILL;
        end else if (ack_need_rsp_i && !ack_is_prefetch_i) begin
          state_d = RF_RSP;
        end else begin
          state_d = RF_IDLE;
          err_d   = 1'b0;
        end
      end
      RF_REFILL: begin
        if (refill_ready_i) begin
          if (entry_q.need_rsp && !entry_q.is_prefetch) begin
            state_d = RF_RSP;
          end else begin
            state_d = RF_IDLE;
            err_d   = 1'b0;
          end
        end
      end
      RF_RSP: begin
        if (rsp_ready_i) begin
          state_d = RF_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= '0;
      entry_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      id_q    <= id_d;
      entry_q <= entry_d;
      word_q  <= word_d;
    end
  end

  assign mem_rsp_ready_o = (state_q == RF_IDLE) || (state_q == RF_RECV);
  assign ack_o           = (state_q == RF_ACK_REQ) && ack_gnt_i;
  assign ack_cs_o        = ack_o;
  assign ack_set_o       = id_q[MSET_W-1:0];
  assign ack_way_o       = id_q[MSET_W +: MWAY_W];

  assign refill_valid_o  = (state_q == RF_REFILL);
  assign refill_set_o    = entry_q.cache_set;
  assign refill_tag_o    = entry_q.cache_tag;
  assign refill_data_o   = line;

  assign rsp_valid_o     = (state_q == RF_RSP);
  assign rsp_data_o      = line[word_q*WORD_W +: WORD_W];
  assign rsp_tid_o       = entry_q.req_id;
  assign rsp_sid_o       = entry_q.src_id;
  assign rsp_error_o     = err_q;

  assign busy_o          = (state_q != RF_IDLE);

endmodule

// File: tb/tb_hpdcache_refill_ack.sv
// Randomized bench for hpdcache_refill_ack against a transaction-level line/flow model.
module tb_hpdcache_refill_ack;

  localparam int BEATS  = 2;
  localparam int BEAT_W = 128;
  localparam int WORD_W = 64;
  localparam int LINE_W = BEATS * BEAT_W;
  localparam int ID_W   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_ni;
  logic              mem_rsp_valid_i, mem_rsp_ready_o;
  logic [ID_W-1:0]   mem_rsp_id_i;
  logic [BEAT_W-1:0] mem_rsp_data_i;
  logic              mem_rsp_error_i, mem_rsp_last_i;
  logic              ack_gnt_i, ack_o, ack_cs_o;
  logic [4:0]        ack_set_o;
  logic [0:0]        ack_way_o;
  logic [5:0]        ack_req_id_i;
  logic [2:0]        ack_src_id_i;
  logic [6:0]        ack_cache_set_i;
  logic [23:0]       ack_cache_tag_i;
  logic [1:0]        ack_word_i;
  logic              ack_need_rsp_i, ack_is_prefetch_i;
  logic              refill_valid_o, refill_ready_i;
  logic [6:0]        refill_set_o;
  logic [23:0]       refill_tag_o;
  logic [LINE_W-1:0] refill_data_o;
  logic              rsp_valid_o, rsp_ready_i;
  logic [WORD_W-1:0] rsp_data_o;
  logic [5:0]        rsp_tid_o;
  logic [2:0]        rsp_sid_o;
  logic              rsp_error_o, busy_o;

  hpdcache_refill_ack #(
    .MSHR_SETS (32),
    .MSHR_WAYS (2),
    .BEATS     (BEATS),
    .BEAT_W    (BEAT_W),
    .WORD_W    (WORD_W)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .mem_rsp_valid_i   (mem_rsp_valid_i),
    .mem_rsp_ready_o   (mem_rsp_ready_o),
    .mem_rsp_id_i      (mem_rsp_id_i),
    .mem_rsp_data_i    (mem_rsp_data_i),
    .mem_rsp_error_i   (mem_rsp_error_i),
    .mem_rsp_last_i    (mem_rsp_last_i),
    .ack_gnt_i         (ack_gnt_i),
    .ack_o             (ack_o),
    .ack_cs_o          (ack_cs_o),
    .ack_set_o         (ack_set_o),
    .ack_way_o         (ack_way_o),
    .ack_req_id_i      (ack_req_id_i),
    .ack_src_id_i      (ack_src_id_i),
    .ack_cache_set_i   (ack_cache_set_i),
    .ack_cache_tag_i   (ack_cache_tag_i),
    .ack_word_i        (ack_word_i),
    .ack_need_rsp_i    (ack_need_rsp_i),
    .ack_is_prefetch_i (ack_is_prefetch_i),
    .refill_valid_o    (refill_valid_o),
    .refill_ready_i    (refill_ready_i),
    .refill_set_o      (refill_set_o),
    .refill_tag_o      (refill_tag_o),
    .refill_data_o     (refill_data_o),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_data_o        (rsp_data_o),
    .rsp_tid_o         (rsp_tid_o),
    .rsp_sid_o         (rsp_sid_o),
    .rsp_error_o       (rsp_error_o),
    .busy_o            (busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the line buffer contents: slot i holds the last beat i delivered since reset.
  logic [BEAT_W-1:0] mline [BEATS];

  task automatic chk_eq(input string tag, input logic [LINE_W-1:0] got,
                        input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] model_line();
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < BEATS; i++) l[i*BEAT_W +: BEAT_W] = mline[i];
    return l;
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic scramble_entry();
    ack_req_id_i      = 6'($urandom);
    ack_src_id_i      = 3'($urandom);
    ack_cache_set_i   = 7'($urandom);
    ack_cache_tag_i   = 24'($urandom);
    ack_word_i        = 2'($urandom);
    ack_need_rsp_i    = 1'($urandom);
    ack_is_prefetch_i = 1'($urandom);
  endtask

  task automatic run_txn(input int nb, input logic [BEATS-1:0] errs, input bit last_final,
                         input bit need, input bit pf, input int word, input int gd,
                         input int rd, input int sd, input bit abort, input bit gaps,
                         input logic [ID_W-1:0] id);
    bit exp_err, exp_rsp;
    logic [5:0]  tid;
    logic [2:0]  sid;
    logic [6:0]  cset;
    logic [23:0] ctag;
    logic [LINE_W-1:0] exp_line;
    logic [WORD_W-1:0] exp_word;

    exp_err = (nb < BEATS);
    for (int i = 0; i < nb; i++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        ack_gnt_i = 1'($urandom);
        #1 chk_eq("gap_ready", mem_rsp_ready_o, 1'b1);
        chk_eq("gap_ack", ack_o, 1'b0);
      end
      @(negedge clk);
      mem_rsp_valid_i = 1'b1;
      mem_rsp_id_i    = id;
      mem_rsp_data_i  = rand_beat();
      mem_rsp_error_i = errs[i];
      mem_rsp_last_i  = (i == nb - 1) ? ((nb < BEATS) ? 1'b1 : last_final) : 1'b0;
      ack_gnt_i       = 1'($urandom);
      mline[i]        = mem_rsp_data_i;
      exp_err         = exp_err | errs[i];
      #1 chk_eq("beat_ready", mem_rsp_ready_o, 1'b1);
      chk_eq("beat_ack", ack_o, 1'b0);
    end

    for (int k = 0; k < gd; k++) begin
      @(negedge clk);
      mem_rsp_valid_i = 1'($urandom);
      mem_rsp_data_i  = rand_beat();
      ack_gnt_i       = 1'b0;
      #1 chk_eq("wait_ack", {ack_o, ack_cs_o}, 2'b00);
      chk_eq("wait_ready", mem_rsp_ready_o, 1'b0);
      chk_eq("wait_busy", busy_o, 1'b1);
    end
    @(negedge clk);
    mem_rsp_valid_i = 1'($urandom);
    mem_rsp_data_i  = rand_beat();
    ack_gnt_i       = 1'b1;
    #1 chk_eq("ack_pulse", {ack_o, ack_cs_o}, 2'b11);
    chk_eq("ack_set", ack_set_o, id[4:0]);
    chk_eq("ack_way", ack_way_o, id[5]);

    tid = 6'($urandom); sid = 3'($urandom); cset = 7'($urandom); ctag = 24'($urandom);
    @(negedge clk);
    ack_gnt_i         = 1'($urandom);
    ack_req_id_i      = tid;
    ack_src_id_i      = sid;
    ack_cache_set_i   = cset;
    ack_cache_tag_i   = ctag;
    ack_word_i        = 2'(word);
    ack_need_rsp_i    = need;
    ack_is_prefetch_i = pf;
    #1 chk_eq("ack_once", ack_o, 1'b0);
    chk_eq("rd_ready", mem_rsp_ready_o, 1'b0);

    exp_line = model_line();
    exp_rsp  = need && !pf;
    if (!exp_err) begin
      for (int k = 0; k <= rd; k++) begin
        @(negedge clk);
        scramble_entry();
        ack_gnt_i       = 1'($urandom);
        mem_rsp_valid_i = 1'($urandom);
        refill_ready_i  = (k == rd);
        #1 chk_eq("refill_valid", refill_valid_o, 1'b1);
        chk_eq("refill_set", refill_set_o, cset);
        chk_eq("refill_tag", refill_tag_o, ctag);
        chk_eq("refill_data", refill_data_o, exp_line);
        chk_eq("refill_no_ack", ack_o, 1'b0);
        chk_eq("refill_no_rsp", rsp_valid_o, 1'b0);
        if (abort && k == 0) begin
          #1 rst_ni = 1'b0;
          #1 chk_eq("rst_valids", {refill_valid_o, rsp_valid_o, ack_o, ack_cs_o, busy_o}, 5'b0);
          chk_eq("rst_data", refill_data_o, '0);
          chk_eq("rst_rsp_data", rsp_data_o, '0);
          @(negedge clk);
          refill_ready_i  = 1'b0;
          mem_rsp_valid_i = 1'b0;
          rst_ni          = 1'b1;
          for (int i = 0; i < BEATS; i++) mline[i] = '0;
          #1 chk_eq("rst_idle", {busy_o, mem_rsp_ready_o}, 2'b01);
          return;
        end
      end
    end

    exp_word = WORD_W'(exp_line >> (word * WORD_W));
    if (exp_rsp) begin
      for (int k = 0; k <= sd; k++) begin
        @(negedge clk);
        scramble_entry();
        mem_rsp_valid_i = 1'($urandom);
        refill_ready_i  = 1'($urandom);
        rsp_ready_i     = (k == sd);
        #1 chk_eq("rsp_valid", rsp_valid_o, 1'b1);
        chk_eq("rsp_no_refill", refill_valid_o, 1'b0);
        chk_eq("rsp_data", rsp_data_o, exp_word);
        chk_eq("rsp_tid", rsp_tid_o, tid);
        chk_eq("rsp_sid", rsp_sid_o, sid);
        chk_eq("rsp_error", rsp_error_o, exp_err);
      end
    end

    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    refill_ready_i  = 1'b0;
    rsp_ready_i     = 1'b0;
    ack_gnt_i       = 1'($urandom);
    #1 chk_eq("end_idle", {busy_o, mem_rsp_ready_o, refill_valid_o, rsp_valid_o, ack_o},
              5'b01000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_id_i = '0; mem_rsp_data_i = '0;
    mem_rsp_error_i = 1'b0; mem_rsp_last_i = 1'b0; ack_gnt_i = 1'b0;
    refill_ready_i = 1'b0; rsp_ready_i = 1'b0;
    scramble_entry();
    for (int i = 0; i < BEATS; i++) mline[i] = '0;

    repeat (3) @(negedge clk);
    #1 chk_eq("reset_valids", {busy_o, ack_o, ack_cs_o, refill_valid_o, rsp_valid_o}, 5'b0);
    chk_eq("reset_data", refill_data_o, '0);
    chk_eq("reset_rsp", {rsp_data_o, rsp_error_o}, '0);
    @(negedge clk);
    rst_ni = 1'b1;

    // nb, errs, last_final, need, pf, word, gnt delay, refill delay, rsp delay, abort, gaps, id
    run_txn(2, 2'b00, 1, 1, 0, 3, 0, 0, 0, 0, 0, 6'b1_00101);
    run_txn(2, 2'b00, 0, 1, 0, 1, 4, 1, 2, 0, 0, 6'($urandom));
    run_txn(2, 2'b01, 1, 1, 0, 2, 0, 0, 1, 0, 0, 6'($urandom));
    run_txn(2, 2'b01, 1, 1, 1, 0, 1, 0, 0, 0, 0, 6'($urandom));
    run_txn(2, 2'b00, 1, 1, 1, 0, 0, 3, 0, 0, 0, 6'($urandom));
    run_txn(1, 2'b00, 1, 1, 0, 3, 0, 0, 0, 0, 0, 6'($urandom));
    run_txn(2, 2'b00, 1, 1, 0, 0, 1, 2, 0, 1, 0, 6'($urandom));
    run_txn(1, 2'b00, 1, 1, 0, 2, 0, 0, 0, 0, 0, 6'($urandom));

    for (int t = 0; t < 60; t++) begin
      int nb;
      logic [BEATS-1:0] errs;
      nb   = ($urandom % 4 == 0) ? 1 : 2;
      errs = ($urandom % 5 == 0) ? 2'($urandom) : 2'b00;
      if (nb == 1) errs[1] = 1'b0;
      run_txn(nb, errs, 1'($urandom), 1'($urandom), ($urandom % 4 == 0),
              int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
              int'($urandom % 4), 0, 1, 6'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
